coin_credit_unit: RTL and testbench

- Front end of the vending machine: debounces the raw coin and refund buttons, accumulates credit and handles vend and refund requests.
- Presents the current credit as `value[7:0]` (0..99), the binary input consumed by the seven-segment display driver.
- Sits between the board buttons and both the display and the product-selection controller.

---
 rtl/coin_credit_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_coin_credit_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_unit.sv
// -----------------------------------------------------------------------------
// coin_credit_unit
//   Vending machine front end. Conditions the three raw buttons (2-flop
//   synchronizer + debounce + rising-edge event), accumulates coin credit,
//   and services vend and refund requests. After any vend or refund the unit
//   sits in LOCK for LOCK_CYCLES cycles.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   coin_a_btn   raw coin-A button (async, bouncy)
//   coin_b_btn   raw coin-B button (async, bouncy)
//   refund_btn   raw refund button (async, bouncy)
//   vend_req     one-cycle vend request, synchronous to clk
//   price[7:0]   item price, sampled with vend_req
//   value[7:0]   current credit, 0..MAX_CREDIT, to the display driver
//   vend_ok      pulse: vend accepted, price deducted
//   vend_fail    pulse: vend rejected, insufficient credit
//   change[7:0]  last refunded amount, held until the next refund
//   refund_done  pulse: change is valid
//   sat          pulse: a coin was clipped at MAX_CREDIT
//   busy         high while in LOCK
// -----------------------------------------------------------------------------
module coin_credit_unit #(
  parameter int DEB_CYCLES  = 16,
  parameter int COIN_A_VAL  = 1,
  parameter int COIN_B_VAL  = 5,
  parameter int MAX_CREDIT  = 99,
  parameter int LOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_a_btn,
  input  logic       coin_b_btn,
  input  logic       refund_btn,
  input  logic       vend_req,
  input  logic [7:0] price,
  output logic [7:0] value,
  output logic       vend_ok,
  output logic       vend_fail,
  output logic [7:0] change,
  output logic       refund_done,
  output logic       sat,
  output logic       busy
);

  localparam int DCW   = $clog2(DEB_CYCLES);
  localparam int LCW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int NBTN  = 3;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_R = 2;

  localparam logic [7:0] MAX_C     = 8'(MAX_CREDIT);
  localparam logic [8:0] MAX_C9    = 9'(MAX_CREDIT);
  localparam logic [8:0] COIN_A9   = 9'(COIN_A_VAL);
  localparam logic [8:0] COIN_B9   = 9'(COIN_B_VAL);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning: one identical channel per button.
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_event;

  assign btn_raw = {refund_btn, coin_b_btn, coin_a_btn};

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic           sync1_reg;
      logic           sync2_reg;
      logic           level_reg;
      logic           level_d_reg;
      logic           event_reg;
      logic [DCW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          event_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          // The counter tracks how long the synchronized sample has disagreed
          // with the accepted level; the DEB_CYCLES-th disagreeing sample
          // flips the level.
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DCW'(DEB_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DCW'(1);
          end
          level_d_reg <= level_reg;
          event_reg   <= level_reg & ~level_d_reg;
        end
      end

      assign btn_event[gi] = event_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Credit FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t         state_reg;
  logic [7:0]     credit_reg;
  logic [7:0]     change_reg;
  logic [LCW-1:0] lock_cnt_reg;
  logic           pend_a_reg;
  logic           pend_b_reg;
  logic           vend_ok_reg;
  logic           vend_fail_reg;
  logic           refund_done_reg;
  logic           sat_reg;
  logic           busy_reg;

  // A coin event arriving this cycle counts as pending immediately, so an
  // idle unit can consume it without first parking it in the flag.
  logic       pend_a_eff;
  logic       pend_b_eff;
  logic [8:0] sum_a;
  logic [8:0] sum_b;
  logic       over_a;
  logic       over_b;

  assign pend_a_eff = pend_a_reg | btn_event[BTN_A];
  assign pend_b_eff = pend_b_reg | btn_event[BTN_B];
  // 9-bit sums so a coin near the ceiling cannot wrap before the clip test.
  assign sum_a  = {1'b0, credit_reg} + COIN_A9;
  assign sum_b  = {1'b0, credit_reg} + COIN_B9;
  assign over_a = (sum_a > MAX_C9);
  assign over_b = (sum_b > MAX_C9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      credit_reg      <= '0;
      change_reg      <= '0;
      lock_cnt_reg    <= '0;
      pend_a_reg      <= 1'b0;
      pend_b_reg      <= 1'b0;
      vend_ok_reg     <= 1'b0;
      vend_fail_reg   <= 1'b0;
      refund_done_reg <= 1'b0;
      sat_reg         <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      vend_ok_reg     <= 1'b0;
      vend_fail_reg   <= 1'b0;
      refund_done_reg <= 1'b0;
      sat_reg         <= 1'b0;
      // Coin flags latch new events by default; the consuming branch below
      // overrides its own flag.
      pend_a_reg      <= pend_a_eff;
      pend_b_reg      <= pend_b_eff;

      case (state_reg)
        ST_IDLE: begin
          if (btn_event[BTN_R]) begin
            change_reg      <= credit_reg;
            credit_reg      <= '0;
            refund_done_reg <= 1'b1;
            state_reg       <= ST_LOCK;
            busy_reg        <= 1'b1;
            lock_cnt_reg    <= '0;
          end else if (vend_req && (price <= credit_reg)) begin
            credit_reg   <= credit_reg - price;
            vend_ok_reg  <= 1'b1;
            state_reg    <= ST_LOCK;
            busy_reg     <= 1'b1;
            lock_cnt_reg <= '0;
          end else if (vend_req) begin
            vend_fail_reg <= 1'b1;
          end else if (pend_a_eff) begin
            credit_reg <= over_a ? MAX_C : sum_a[7:0];
            sat_reg    <= over_a;
            pend_a_reg <= 1'b0;
          end else if (pend_b_eff) begin
            credit_reg <= over_b ? MAX_C : sum_b[7:0];
            sat_reg    <= over_b;
            pend_b_reg <= 1'b0;
          end
        end

        ST_LOCK: begin
          // Vend requests and refund events are discarded here; coins only
          // accumulate in their pending flags.
          if (lock_cnt_reg == LOCK_LAST) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            lock_cnt_reg <= '0;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + LCW'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign value       = credit_reg;
  assign change      = change_reg;
  assign vend_ok     = vend_ok_reg;
  assign vend_fail   = vend_fail_reg;
  assign refund_done = refund_done_reg;
  assign sat         = sat_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_coin_credit_unit.sv
module tb_coin_credit_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_a_btn = 1'b0;
  logic       coin_b_btn = 1'b0;
  logic       refund_btn = 1'b0;
  logic       vend_req = 1'b0;
  logic [7:0] price = 8'd0;
  logic [7:0] value;
  logic       vend_ok;
  logic       vend_fail;
  logic [7:0] change;
  logic       refund_done;
  logic       sat;
  logic       busy;

  always #5 clk = ~clk;

  coin_credit_unit #(
    .DEB_CYCLES (4),
    .COIN_A_VAL (1),
    .COIN_B_VAL (5),
    .MAX_CREDIT (99),
    .LOCK_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_a_btn (coin_a_btn),
    .coin_b_btn (coin_b_btn),
    .refund_btn (refund_btn),
    .vend_req   (vend_req),
    .price      (price),
    .value      (value),
    .vend_ok    (vend_ok),
    .vend_fail  (vend_fail),
    .change     (change),
    .refund_done(refund_done),
    .sat        (sat),
    .busy       (busy)
  );

  typedef struct packed {
    logic       ok;
    logic       vf;
    logic       rd;
    logic       st;
    logic [7:0] val;
    logic [7:0] chg;
  } rec_t;

  rec_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_credit = 0;
  int         m_change = 0;
  logic [7:0] prev_val = 8'd0;

  // ---------------- reference model: pushes expected output records --------
  function automatic void push_rec(input logic ok, input logic vf, input logic rd, input logic st);
    rec_t r;
    r.ok  = ok;
    r.vf  = vf;
    r.rd  = rd;
    r.st  = st;
    r.val = 8'(m_credit);
    r.chg = 8'(m_change);
    exp_q.push_back(r);
  endfunction

  function automatic void exp_coin(input int amt);
    int   s;
    logic st;
    s        = m_credit + amt;
    st       = (s > 99);
    m_credit = st ? 99 : s;
    push_rec(1'b0, 1'b0, 1'b0, st);
  endfunction

  function automatic void exp_vend(input int p);
    if (p <= m_credit) begin
      m_credit = m_credit - p;
      push_rec(1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      push_rec(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endfunction

  function automatic void exp_refund();
    m_change = m_credit;
    m_credit = 0;
    push_rec(1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // ---------------- output monitor: pops one record per output event -------
  always @(negedge clk) begin
    rec_t obs;
    rec_t e;
    if (rst) begin
      prev_val = value;
    end else begin
      if (vend_ok || vend_fail || refund_done || sat || (value !== prev_val)) begin
        obs.ok  = vend_ok;
        obs.vf  = vend_fail;
        obs.rd  = refund_done;
        obs.st  = sat;
        obs.val = value;
        obs.chg = change;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output t=%0t got ok=%b vf=%b rd=%b sat=%b value=%0d change=%0d required none",
                   $time, obs.ok, obs.vf, obs.rd, obs.st, obs.val, obs.chg);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL output_txn t=%0t got ok=%b vf=%b rd=%b sat=%b value=%0d change=%0d required ok=%b vf=%b rd=%b sat=%b value=%0d change=%0d",
                     $time, obs.ok, obs.vf, obs.rd, obs.st, obs.val, obs.chg,
                     e.ok, e.vf, e.rd, e.st, e.val, e.chg);
          end else begin
            $display("txn t=%0t ok=%b vf=%b rd=%b sat=%b value=%0d change=%0d",
                     $time, obs.ok, obs.vf, obs.rd, obs.st, obs.val, obs.chg);
          end
        end
      end
      prev_val = value;
    end
  end

  // ---------------- stimulus helpers (no checking) -------------------------
  task automatic press(input logic a, input logic b, input logic r);
    @(negedge clk);
    coin_a_btn = a;
    coin_b_btn = b;
    refund_btn = r;
    repeat (10) @(negedge clk);
    coin_a_btn = 1'b0;
    coin_b_btn = 1'b0;
    refund_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic vend(input logic [7:0] p);
    @(negedge clk);
    vend_req = 1'b1;
    price    = p;
    @(negedge clk);
    vend_req = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (value !== 8'd0) begin errors++; $display("FAIL reset_value got %0d required 0", value); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (change !== 8'd0) begin errors++; $display("FAIL reset_change got %0d required 0", change); end
    checks++;
    if ({vend_ok, vend_fail, refund_done, sat} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got %b required 0000", {vend_ok, vend_fail, refund_done, sat});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_coin_b();
    exp_coin(5);
    @(negedge clk);
    coin_b_btn = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (value !== 8'd0) begin errors++; $display("FAIL coin_latency_early got %0d required 0", value); end
    @(negedge clk);
    checks++; if (value !== 8'd5) begin errors++; $display("FAIL coin_latency_8 got %0d required 5", value); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL coin_b_sat got %b required 0", sat); end
    repeat (2) @(negedge clk);
    coin_b_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_credit = 0;
    m_change = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // three 3-cycle glitches, each shorter than the debounce window
    for (int g = 0; g < 3; g++) begin
      coin_a_btn = 1'b1;
      repeat (3) @(negedge clk);
      coin_a_btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    exp_coin(1);
    coin_a_btn = 1'b1;
    repeat (12) @(negedge clk);
    coin_a_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (value !== 8'd1) begin errors++; $display("FAIL bounce_value got %0d required 1", value); end
  endtask

  task automatic test_vend();
    int busy_cnt;
    exp_coin(5); press(1'b0, 1'b1, 1'b0);
    exp_coin(5); press(1'b0, 1'b1, 1'b0);
    exp_coin(1); press(1'b1, 1'b0, 1'b0);
    checks++; if (value !== 8'd12) begin errors++; $display("FAIL vend_setup got %0d required 12", value); end
    exp_vend(15);
    vend(8'd15);
    checks++; if (vend_fail !== 1'b1) begin errors++; $display("FAIL vend_fail_pulse got %b required 1", vend_fail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vend_fail_busy got %b required 0", busy); end
    exp_vend(7);
    vend(8'd7);
    checks++; if (vend_ok !== 1'b1) begin errors++; $display("FAIL vend_ok_pulse got %b required 1", vend_ok); end
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (i == 1) begin
        vend_req = 1'b1;   // lands in LOCK cycle 3
        price    = 8'd3;
      end else begin
        vend_req = 1'b0;
      end
    end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL lock_length got %0d required 8", busy_cnt); end
    checks++; if (value !== 8'd5) begin errors++; $display("FAIL vend_value got %0d required 5", value); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) begin exp_coin(5); press(1'b0, 1'b1, 1'b0); end
    for (int i = 0; i < 2; i++) begin exp_coin(1); press(1'b1, 1'b0, 1'b0); end
    checks++; if (value !== 8'd97) begin errors++; $display("FAIL sat_setup got %0d required 97", value); end
    exp_coin(5); press(1'b0, 1'b1, 1'b0);
    checks++; if (value !== 8'd99) begin errors++; $display("FAIL sat_clip_b got %0d required 99", value); end
    exp_coin(1); press(1'b1, 1'b0, 1'b0);
    checks++; if (value !== 8'd99) begin errors++; $display("FAIL sat_clip_a got %0d required 99", value); end
  endtask

  task automatic test_refund_coin();
    exp_vend(79);
    vend(8'd79);
    repeat (9) @(negedge clk);
    checks++; if (value !== 8'd20) begin errors++; $display("FAIL refund_setup got %0d required 20", value); end
    exp_refund();
    exp_coin(1);
    @(negedge clk);
    coin_a_btn = 1'b1;
    refund_btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 8) begin
        checks++; if (refund_done !== 1'b1) begin errors++; $display("FAIL refund_pulse got %b required 1", refund_done); end
        checks++; if (change !== 8'd20) begin errors++; $display("FAIL refund_change got %0d required 20", change); end
        checks++; if (value !== 8'd0) begin errors++; $display("FAIL refund_value got %0d required 0", value); end
      end
      if (k == 10) begin
        coin_a_btn = 1'b0;
        refund_btn = 1'b0;
      end
      if (k == 16) begin
        checks++; if (value !== 8'd0) begin errors++; $display("FAIL pend_during_lock got %0d required 0", value); end
      end
      if (k == 17) begin
        checks++; if (value !== 8'd1) begin errors++; $display("FAIL pend_after_lock got %0d required 1", value); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_vend(0);
    vend(8'd0);
    checks++; if (vend_ok !== 1'b1) begin errors++; $display("FAIL price0_ok got %b required 1", vend_ok); end
    checks++; if (value !== 8'd1) begin errors++; $display("FAIL price0_value got %0d required 1", value); end
    repeat (9) @(negedge clk);
    exp_vend(200);
    exp_vend(1);
    @(negedge clk);
    vend_req = 1'b1;
    price    = 8'd200;
    @(negedge clk);
    checks++; if (vend_fail !== 1'b1) begin errors++; $display("FAIL price_over_max got %b required 1", vend_fail); end
    price = 8'd1;
    @(negedge clk);
    vend_req = 1'b0;
    checks++; if (vend_ok !== 1'b1) begin errors++; $display("FAIL exact_credit_ok got %b required 1", vend_ok); end
    checks++; if (value !== 8'd0) begin errors++; $display("FAIL exact_credit_value got %0d required 0", value); end
    repeat (9) @(negedge clk);
    exp_refund();
    press(1'b0, 1'b0, 1'b1);
    checks++; if (change !== 8'd0) begin errors++; $display("FAIL refund_zero_change got %0d required 0", change); end
    // coin event in the same cycle as a vend request
    exp_vend(0);
    exp_coin(5);
    @(negedge clk);
    coin_b_btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      vend_req = 1'b0;
      if (k == 7) begin
        vend_req = 1'b1;
        price    = 8'd0;
      end
      if (k == 8) begin
        checks++; if (vend_ok !== 1'b1) begin errors++; $display("FAIL coin_vs_vend_ok got %b required 1", vend_ok); end
        checks++; if (value !== 8'd0) begin errors++; $display("FAIL coin_vs_vend_value got %0d required 0", value); end
      end
      if (k == 10) coin_b_btn = 1'b0;
      if (k == 17) begin
        checks++; if (value !== 8'd5) begin errors++; $display("FAIL coin_after_vend got %0d required 5", value); end
      end
    end
  endtask

  task automatic test_reset_lock();
    for (int i = 0; i < 5; i++) begin exp_coin(5); press(1'b0, 1'b1, 1'b0); end
    checks++; if (value !== 8'd30) begin errors++; $display("FAIL rst_setup got %0d required 30", value); end
    exp_vend(0);
    vend(8'd0);
    coin_a_btn = 1'b1;       // debounce in flight when reset hits
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (value !== 8'd0) begin errors++; $display("FAIL rst_async_value got %0d required 0", value); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b required 0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_queue got %0d required 0", exp_q.size()); end
    exp_q.delete();
    m_credit   = 0;
    m_change   = 0;
    coin_a_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (value !== 8'd0) begin errors++; $display("FAIL post_rst_value got %0d required 0", value); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b required 0", busy); end
    checks++; if (change !== 8'd0) begin errors++; $display("FAIL post_rst_change got %0d required 0", change); end
  endtask

  initial begin
    test_reset();
    test_clean_coin_b();
    test_bounce();
    test_vend();
    test_saturation();
    test_refund_coin();
    test_back_to_back();
    test_reset_lock();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
